pe_row_sched: RTL

- Sequences one convolution row tile through a PE row.
- Generates read addresses for ia_row_mem (input-activation row) and weight_row_mem.
- Emits per-beat valid, first and last markers so the PE multiply-accumulates one output pixel per K beats and presents psum on the last beat.
- Sits between the NPU top-level config/start logic and the PE net. Loop order: oc (outer), ox, kx (inner).

---
 rtl/npu_pkg.sv | 36 +++
 rtl/pe_row_addr_gen.sv | 91 +++++++++
 rtl/pe_row_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared definitions for the PE row scheduler: FSM encoding, address widths
// and the configuration legality check.
package npu_pkg;

  localparam int K_MAX     = 3;
  localparam int IA_ADDR_W = 6;
  localparam int W_ADDR_W  = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } sched_state_e;

  // A config is usable only if every loop bound is non-empty, the kernel fits
  // the row, and all OC*K weights fit in a weight row memory of w_depth words.
  function automatic logic cfg_legal(input logic [2:0] k,
                                     input logic [5:0] img_w,
                                     input logic [7:0] oc,
                                     input logic [2:0] stride,
                                     input int unsigned w_depth);
    logic [10:0] w_words;
    logic        ok;
    w_words = 11'(oc) * 11'(k);
    ok = 1'b1;
    if (k == 3'd0 || k > 3'(K_MAX)) ok = 1'b0;
    if (stride == 3'd0)             ok = 1'b0;
    if (oc == 8'd0)                 ok = 1'b0;
    if (img_w < {3'b000, k})        ok = 1'b0;
    if (32'(w_words) > w_depth)     ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/pe_row_addr_gen.sv
// Loop counters for one row tile: kx (inner), ox (middle), oc (outer), plus
// the ia window base and weight base that the read addresses are built from.
module pe_row_addr_gen
  import npu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       advance_i,
  input  logic [2:0] k_i,
  input  logic [5:0] img_w_i,
  input  logic [2:0] stride_i,
  input  logic [7:0] oc_num_i,
  output logic [1:0] kx_o,
  output logic [5:0] ox_o,
  output logic [5:0] ox_base_o,
  output logic [7:0] oc_o,
  output logic [8:0] w_base_o,
  output logic       kx_last_o,
  output logic       ox_last_o,
  output logic       oc_last_o
);

  logic [1:0] kx_q, kx_d;
  logic [5:0] ox_q, ox_d;
  logic [5:0] ox_base_q, ox_base_d;
  logic [7:0] oc_q, oc_d;
  logic [8:0] w_base_q, w_base_d;
  logic [6:0] next_end;

  // End of the next output window; 7 bits so IMG_W=63 with STRIDE=7 cannot wrap.
  assign next_end  = {1'b0, ox_base_q} + {4'b0000, stride_i} + {4'b0000, k_i};
  assign kx_last_o = ({1'b0, kx_q} == (k_i - 3'd1));
  assign ox_last_o = (next_end > {1'b0, img_w_i});
  assign oc_last_o = (oc_q == (oc_num_i - 8'd1));

  assign kx_o      = kx_q;
  assign ox_o      = ox_q;
  assign ox_base_o = ox_base_q;
  assign oc_o      = oc_q;
  assign w_base_o  = w_base_q;

  // Next-state of the nested loop counters; they move only on an issued beat.
  always_comb begin
    kx_d      = kx_q;
    ox_d      = ox_q;
    ox_base_d = ox_base_q;
    oc_d      = oc_q;
    w_base_d  = w_base_q;
    if (clear_i) begin
      kx_d      = '0;
      ox_d      = '0;
      ox_base_d = '0;
      oc_d      = '0;
      w_base_d  = '0;
    end else if (advance_i) begin
      if (kx_last_o) begin
        kx_d = '0;
        if (ox_last_o) begin
          ox_base_d = '0;
          ox_d      = '0;
          w_base_d  = w_base_q + {6'b000000, k_i};
          oc_d      = oc_q + 8'd1;
        end else begin
          ox_base_d = ox_base_q + {3'b000, stride_i};
          ox_d      = ox_q + 6'd1;
        end
      end else begin
        kx_d = kx_q + 2'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      kx_q      <= '0;
      ox_q      <= '0;
      ox_base_q <= '0;
      oc_q      <= '0;
      w_base_q  <= '0;
    end else begin
      kx_q      <= kx_d;
      ox_q      <= ox_d;
      ox_base_q <= ox_base_d;
      oc_q      <= oc_d;
      w_base_q  <= w_base_d;
    end
  end

endmodule

// File: rtl/pe_row_sched.sv
// Sequences one convolution row tile through a PE row: issues ia/weight reads
// and presents each beat to the PE one cycle later with first/last markers.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; config latched on start
// ST_CHECK | one cycle to validate the latched config
// ST_RUN   | issuing reads, one per cycle unless the PE stalls
// ST_DRAIN | last read issued; waiting for the PE to take the final beat
// ST_FIN   | one-cycle done pulse (cfg_err qualifies it)
module pe_row_sched
  import npu_pkg::*;
#(
  parameter int IA_ROW_MEM_ADDR     = IA_ADDR_W,
  parameter int WEIGHT_ROW_MEM_ADDR = W_ADDR_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [2:0]                     K,
  input  logic [5:0]                     IMG_W,
  input  logic [7:0]                     OC,
  input  logic [2:0]                     STRIDE,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err,
  output logic                           ia_rd_en,
  output logic [IA_ROW_MEM_ADDR-1:0]     ia_rd_addr,
  output logic                           w_rd_en,
  output logic [WEIGHT_ROW_MEM_ADDR-1:0] w_rd_addr,
  output logic                           pe_valid,
  input  logic                           pe_ready,
  output logic                           pe_first,
  output logic                           pe_last,
  output logic [7:0]                     oc_idx,
  output logic [5:0]                     ox_idx
);

  localparam int unsigned W_DEPTH = 1 << WEIGHT_ROW_MEM_ADDR;

  sched_state_e state_q, state_d;
  logic [2:0]   k_q, stride_q;
  logic [5:0]   img_w_q;
  logic [7:0]   oc_q;
  logic         cfg_ok;
  logic         issue, cnt_clear;
  logic         valid_q, first_q, last_q;
  logic [7:0]   oc_idx_q;
  logic [5:0]   ox_idx_q;

  logic [1:0]   kx;
  logic [5:0]   ox, ox_base;
  logic [7:0]   oc_cnt;
  logic [8:0]   w_base;
  logic         kx_last, ox_last, oc_last;

  assign cfg_ok = cfg_legal(k_q, img_w_q, oc_q, stride_q, W_DEPTH);

  pe_row_addr_gen u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (cnt_clear),
    .advance_i (issue),
    .k_i       (k_q),
    .img_w_i   (img_w_q),
    .stride_i  (stride_q),
    .oc_num_i  (oc_q),
    .kx_o      (kx),
    .ox_o      (ox),
    .ox_base_o (ox_base),
    .oc_o      (oc_cnt),
    .w_base_o  (w_base),
    .kx_last_o (kx_last),
    .ox_last_o (ox_last),
    .oc_last_o (oc_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Config is captured only from IDLE so a stray start mid-run cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q      <= '0;
      img_w_q  <= '0;
      oc_q     <= '0;
      stride_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      k_q      <= K;
      img_w_q  <= IMG_W;
      oc_q     <= OC;
      stride_q <= STRIDE;
    end
  end

  // Next-state, read issue and counter clear.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    cnt_clear = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_CHECK;
      ST_CHECK: begin
        if (cfg_ok) begin
          cnt_clear = 1'b1;
          state_d   = ST_RUN;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_RUN: begin
        issue = !valid_q || pe_ready;
        if (issue && kx_last && ox_last && oc_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (!valid_q || pe_ready) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // One-deep beat register: tags line up with the memory data one cycle after issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      oc_idx_q <= '0;
      ox_idx_q <= '0;
    end else if (issue) begin
      valid_q  <= 1'b1;
      first_q  <= (kx == 2'd0);
      last_q   <= kx_last;
      oc_idx_q <= oc_cnt;
      ox_idx_q <= ox;
    end else if (pe_ready) begin
      valid_q  <= 1'b0;
    end
  end

  // Addresses follow the counters, which only move on issue, so they hold through a stall.
  assign ia_rd_en   = issue;
  assign w_rd_en    = issue;
  assign ia_rd_addr = IA_ROW_MEM_ADDR'(ox_base) + IA_ROW_MEM_ADDR'(kx);
  assign w_rd_addr  = WEIGHT_ROW_MEM_ADDR'(w_base) + WEIGHT_ROW_MEM_ADDR'(kx);

  assign pe_valid = valid_q;
  assign pe_first = first_q;
  assign pe_last  = last_q;
  assign oc_idx   = oc_idx_q;
  assign ox_idx   = ox_idx_q;

  assign busy    = (state_q == ST_CHECK) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done    = (state_q == ST_FIN);
  assign cfg_err = (state_q == ST_FIN) && !cfg_ok;

endmodule
